// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } rx_cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy level and synchronous flush.
// Latency: write visible 1 cycle after push; backpressure: push dropped when full unless a pop frees the slot.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign level   = count;
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures completed UART bytes into a FIFO, acks the receiver, drives rts_n with hysteresis, flags overrun.
// Latency: byte visible 1 cycle after capture; backpressure: rts_n to the remote end, bytes dropped with overrun when full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_done,
  input  logic [UART_BYTE_W-1:0]   rx_data,
  output logic                     rx_ack,
  input  logic                     pop,
  output logic [UART_BYTE_W-1:0]   pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     rts_n,
  output logic                     overrun,
  input  logic                     ovr_clr,
  input  logic                     flush
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] RTS_HI_L = LVL_W'(RTS_HI);
  localparam logic [LVL_W-1:0] RTS_LO_L = LVL_W'(RTS_LO);

  rx_cap_state_t state;
  rx_cap_state_t state_nxt;
  logic          capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    rx_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        rx_ack    = 1'b1;
        state_nxt = WAIT_LOW;
      end
      // The receiver's done flag stays high briefly after the ack; wait it out to avoid a double capture.
      WAIT_LOW: begin
        if (!rx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data (rx_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Set has priority over clear; a flushed capture is simply discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (capture && full && !pop && !flush) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rts_n <= 1'b0;
    end else if (level >= RTS_HI_L) begin
      rts_n <= 1'b1;
    end else if (level <= RTS_LO_L) begin
      rts_n <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, RTS_HI=12, RTS_LO=4).
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       pop;
  logic [7:0] pop_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       rts_n;
  logic       overrun;
  logic       ovr_clr;
  logic       flush;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DEPTH(16), .RTS_HI(12), .RTS_LO(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rx_ack   (rx_ack),
    .pop      (pop),
    .pop_data (pop_data),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .rts_n    (rts_n),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full receiver handshake: done high for the capture edge, dropped on ack, back to IDLE.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    cyc();
    rx_done = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    pop     = 1'b0;
    ovr_clr = 1'b0;
    flush   = 1'b0;
    #23;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b required 0", full); end
    checks++; if (rx_ack !== 1'b0)   begin errors++; $display("FAIL reset_rx_ack: got %b required 0", rx_ack); end
    checks++; if (rts_n !== 1'b0)    begin errors++; $display("FAIL reset_rts_n: got %b required 0", rts_n); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
    checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data: got %h required 00", pop_data); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_byte();
    rx_done = 1'b1;
    rx_data = 8'hA5;
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL single_ack_early: got %b required 0", rx_ack); end
    cyc();
    checks++; if (rx_ack !== 1'b1)    begin errors++; $display("FAIL single_ack: got %b required 1", rx_ack); end
    checks++; if (level !== 5'd1)     begin errors++; $display("FAIL single_level: got %0d required 1", level); end
    checks++; if (pop_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", pop_data); end
    checks++; if (empty !== 1'b0)     begin errors++; $display("FAIL single_empty: got %b required 0", empty); end
    rx_done = 1'b0;
    cyc();
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %b required 0", rx_ack); end
    cyc();
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b required 1", empty); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_pop_level: got %0d required 0", level); end
  endtask

  task automatic test_held_done();
    int acks;
    acks = 0;
    rx_done = 1'b1;
    rx_data = 8'h3C;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rx_ack === 1'b1) acks++;
    end
    checks++; if (acks !== 0)     begin errors++; $display("FAIL held_extra_acks: got %0d required 0", acks); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL held_level: got %0d required 1", level); end
    rx_done = 1'b0;
    cyc();
    send_byte(8'h5A);
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL held_second_level: got %0d required 2", level); end
    pop = 1'b1;
    checks++; if (pop_data !== 8'h3C) begin errors++; $display("FAIL held_pop0: got %h required 3c", pop_data); end
    cyc();
    checks++; if (pop_data !== 8'h5A) begin errors++; $display("FAIL held_pop1: got %h required 5a", pop_data); end
    cyc();
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL held_empty: got %b required 1", empty); end
  endtask

  task automatic test_fill_hysteresis();
    for (int i = 0; i < 11; i++) send_byte(8'(i));
    checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL hyst_rts_at11: got %b required 0", rts_n); end
    rx_done = 1'b1;
    rx_data = 8'h0B;
    cyc();
    checks++; if (level !== 5'd12) begin errors++; $display("FAIL hyst_level12: got %0d required 12", level); end
    checks++; if (rts_n !== 1'b0)  begin errors++; $display("FAIL hyst_rts_lag: got %b required 0", rts_n); end
    rx_done = 1'b0;
    cyc();
    checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL hyst_rts_high: got %b required 1", rts_n); end
    cyc();
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (pop_data !== 8'(i)) begin errors++; $display("FAIL hyst_order[%0d]: got %h required %h", i, pop_data, 8'(i)); end
      cyc();
      if (i == 6) begin
        checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL hyst_rts_hold: got %b required 1", rts_n); end
      end
    end
    pop = 1'b0;
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL hyst_level4: got %0d required 4", level); end
    checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL hyst_rts_lag_low: got %b required 1", rts_n); end
    cyc();
    checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL hyst_rts_low: got %b required 0", rts_n); end
    pop = 1'b1;
    for (int i = 8; i < 12; i++) begin
      checks++; if (pop_data !== 8'(i)) begin errors++; $display("FAIL hyst_tail[%0d]: got %h required %h", i, pop_data, 8'(i)); end
      cyc();
    end
    pop = 1'b0;
  endtask

  task automatic test_overrun_wrap();
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b required 1", full); end
    rx_done = 1'b1;
    rx_data = 8'hFF;
    cyc();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", overrun); end
    checks++; if (rx_ack !== 1'b1)  begin errors++; $display("FAIL ovr_ack: got %b required 1", rx_ack); end
    checks++; if (level !== 5'd16)  begin errors++; $display("FAIL ovr_level: got %0d required 16", level); end
    rx_done = 1'b0;
    cyc();
    cyc();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b required 0", overrun); end
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (pop_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovr_order[%0d]: got %h required %h", i, pop_data, 8'h10 + 8'(i)); end
      cyc();
    end
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovr_ff_dropped: got empty=%b data=%h required empty=1", empty, pop_data); end
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
    pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (pop_data !== 8'h20 + 8'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h required %h", i, pop_data, 8'h20 + 8'(i)); end
      cyc();
    end
    pop = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    rx_done = 1'b1;
    rx_data = 8'h77;
    pop     = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_full_overrun: got %b required 0", overrun); end
    checks++; if (level !== 5'd16)  begin errors++; $display("FAIL sim_full_level: got %0d required 16", level); end
    rx_done = 1'b0;
    cyc();
    cyc();
    pop = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (pop_data !== 8'h30 + 8'(i)) begin errors++; $display("FAIL sim_order[%0d]: got %h required %h", i, pop_data, 8'h30 + 8'(i)); end
      cyc();
    end
    checks++; if (pop_data !== 8'h77) begin errors++; $display("FAIL sim_last: got %h required 77", pop_data); end
    cyc();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL sim_drained: got %0d required 0", level); end
    cyc();
    pop = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL sim_empty_pop: got level=%0d empty=%b required 0/1", level, empty); end
    rx_done = 1'b1;
    rx_data = 8'h66;
    pop     = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (level !== 5'd1 || pop_data !== 8'h66) begin errors++; $display("FAIL sim_empty_push_pop: got level=%0d data=%h required 1/66", level, pop_data); end
    rx_done = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 11; i++) send_byte(8'h40 + 8'(i));
    checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL flush_pre_rts: got %b required 1", rts_n); end
    rx_done = 1'b1;
    rx_data = 8'h99;
    flush   = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level: got level=%0d empty=%b required 0/1", level, empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL flush_overrun: got %b required 0", overrun); end
    checks++; if (rx_ack !== 1'b1)  begin errors++; $display("FAIL flush_ack: got %b required 1", rx_ack); end
    checks++; if (rts_n !== 1'b1)   begin errors++; $display("FAIL flush_rts_lag: got %b required 1", rts_n); end
    rx_done = 1'b0;
    cyc();
    checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL flush_rts_low: got %b required 0", rts_n); end
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i));
    rx_done = 1'b1;
    rx_data = 8'hEE;
    cyc();
    checks++; if (rx_ack !== 1'b1 || overrun !== 1'b1 || rts_n !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got ack=%b ovr=%b rts=%b required 1/1/1", rx_ack, overrun, rts_n); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rx_ack !== 1'b0)    begin errors++; $display("FAIL rstmid_ack: got %b required 0", rx_ack); end
    checks++; if (rts_n !== 1'b0)     begin errors++; $display("FAIL rstmid_rts: got %b required 0", rts_n); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rstmid_overrun: got %b required 0", overrun); end
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rstmid_fifo: got level=%0d empty=%b full=%b required 0/1/0", level, empty, full); end
    checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h required 00", pop_data); end
    rx_done = 1'b0;
    #2;
    reset_n = 1'b1;
    cyc();
    rx_done = 1'b1;
    rx_data = 8'hC3;
    cyc();
    checks++; if (rx_ack !== 1'b1 || level !== 5'd1 || pop_data !== 8'hC3) begin errors++; $display("FAIL rstmid_recover: got ack=%b level=%0d data=%h required 1/1/c3", rx_ack, level, pop_data); end
    rx_done = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_held_done();
    test_fill_hysteresis();
    test_overrun_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver core and the APB register block. It captures each byte the receiver completes, acknowledges the receiver's sticky done flag, and stores the byte in a FIFO. Bytes are popped by the register block. The block drives rts_n from FIFO fill level with hysteresis and keeps a sticky overrun flag.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4.
RTS_HI, 12, level at or above which rts_n deasserts (goes 1); must be < DEPTH.
RTS_LO, 4, level at or below which rts_n reasserts (goes 0); must be < RTS_HI.

Ports:
clk  in  1  system clock; same clock as the UART core.
reset_n  in  1  asynchronous active-low reset.
rx_done  in  1  receiver sticky done level; held high until acknowledged.
rx_data  in  8  received byte; stable while rx_done=1.
rx_ack  out  1  one-cycle pulse that clears the receiver done flag.
pop  in  1  register block reads one byte.
pop_data  out  8  head-of-FIFO byte; valid when empty=0.
empty  out  1  FIFO empty.
full  out  1  FIFO full.
level  out  $clog2(DEPTH)+1  current entry count.
rts_n  out  1  flow control to the remote transmitter; 0 = send allowed.
overrun  out  1  sticky; a byte was received while the FIFO was full.
ovr_clr  in  1  clears overrun.
flush  in  1  synchronous clear of the FIFO contents.

Behaviour:
- Reset values:
  - FSM = IDLE; pointers = 0; level = 0.
  - empty = 1, full = 0, rx_ack = 0, rts_n = 0, overrun = 0.
  - pop_data = 8'h00.
- Capture FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE: when rx_done=1, write rx_data into the FIFO in that cycle, or set overrun if full. Go to ACK.
  - ACK: rx_ack=1 for exactly one cycle. Go to WAIT_LOW.
  - WAIT_LOW: stay until rx_done=0, then go to IDLE. This prevents double capture while the receiver clears its flag.
  - Rule: one write per rx_done assertion.
- Write latency: the byte is visible at pop_data and level increments 1 cycle after the IDLE capture edge.
- FIFO:
  - Binary read and write pointers of width $clog2(DEPTH) that wrap at DEPTH.
  - Level counter tracks occupancy; empty = (level==0), full = (level==DEPTH).
  - pop_data is the combinational read of mem[rd_ptr]; it shows 8'h00 when empty.
- Pop rules:
  - pop with empty=1 is ignored; no pointer move, no error.
  - pop is single-cycle; the next byte appears on the following cycle.
- Simultaneous push and pop:
  - Not full and not empty: both occur and level is unchanged.
  - Full: the pop frees a slot and the push is accepted; no overrun.
  - Empty: only the push occurs; the pop is ignored.
- Overrun:
  - A capture while full (and no same-cycle pop) discards the byte and sets overrun.
  - rx_ack is still issued, so the receiver does not stall.
  - ovr_clr clears overrun; a same-cycle set wins over the clear.
- rts_n:
  - Registered. It goes to 1 when level >= RTS_HI and to 0 when level <= RTS_LO; otherwise it holds.
  - It updates one cycle after level changes.
- flush:
  - Pointers and level go to 0 next cycle.
  - rts_n goes to 0 the cycle after that.
  - overrun and the FSM are unaffected.
  - A capture in the same cycle as flush is discarded, not an overrun.
- Asynchronous reset mid-operation aborts any capture; contents are lost.
- level uses width $clog2(DEPTH)+1 so that DEPTH itself is representable; no saturation logic beyond full/empty.

Decomposition:
- Shared package uart_pkg:
  - typedef enum rx_cap_state_t {IDLE, ACK, WAIT_LOW}
  - UART_BYTE_W = 8
- Sub-module sync_fifo (parameter DEPTH, WIDTH) with push/pop/full/empty/level/flush.
- uart_rx_fifo holds the capture FSM, the overrun flag and the rts_n hysteresis.

Test Plan:
1. Single byte: rx_done=1 with rx_data=8'hA5 and held until rx_ack.
   - Exactly one rx_ack pulse 1 cycle after capture.
   - level=1, pop_data=8'hA5, empty=0.
   - pop -> empty=1, level=0.
2. Held rx_done: keep rx_done=1 for 10 cycles after rx_ack.
   - Only one write (level=1); a new byte is captured only after rx_done drops and rises again.
3. Fill and hysteresis with DEPTH=16, RTS_HI=12, RTS_LO=4.
   - Push 12 bytes 0x00..0x0B -> rts_n=1 one cycle after level=12.
   - Pop 8 -> rts_n=0 after level=4.
   - Popped bytes come out in order 0x00..0x07.
4. Overrun and wrap:
   - Push 16 bytes -> full=1.
   - 17th byte 8'hFF -> overrun=1, level stays 16, rx_ack still pulses, 8'hFF is never popped.
   - ovr_clr -> overrun=0.
   - Pop all and push 5 more -> correct order across the pointer wrap.
5. Simultaneous events:
   - Full plus same-cycle capture and pop -> overrun=0, level=16.
   - Empty plus pop -> ignored.
   - flush during capture -> level=0, overrun=0.
6. Reset mid-operation: assert reset_n=0 in ACK state.
   - All outputs at reset values immediately (asynchronous), including rx_ack=0 and rts_n=0.
